// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction-fetch and data accesses onto a single shared memory port.
// Data accesses win ties, but a waiting fetch is forced through after STARVE_LIM data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_IF,
        SERVE_DM
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

    state_t            state, state_nxt;
    logic [3:0]        starve_cnt, starve_nxt;
    logic              mem_req_nxt, mem_we_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic [DATA_W-1:0] if_rdata_nxt, dm_rdata_nxt;
    logic              if_ready_nxt, dm_ready_nxt;
    logic              grant_if, grant_dm;

    assign if_stall = if_req && !if_ready;
    assign dm_stall = dm_req && !dm_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            mem_req    <= mem_req_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            if_rdata   <= if_rdata_nxt;
            dm_rdata   <= dm_rdata_nxt;
            if_ready   <= if_ready_nxt;
            dm_ready   <= dm_ready_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        starve_nxt    = starve_cnt;
        mem_req_nxt   = mem_req;
        mem_we_nxt    = mem_we;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        if_rdata_nxt  = if_rdata;
        dm_rdata_nxt  = dm_rdata;
        if_ready_nxt  = 1'b0;
        dm_ready_nxt  = 1'b0;
        grant_if      = 1'b0;
        grant_dm      = 1'b0;

        case (state)
            IDLE: begin
                // The ready-pulse cycle is skipped so a completed requester's lingering req is not re-granted.
                if (!if_ready && !dm_ready) begin
                    grant_dm = dm_req && !(if_req && starve_cnt == STARVE_MAX);
                    grant_if = if_req && !grant_dm;
                end
                if (grant_dm) begin
                    state_nxt     = SERVE_DM;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = dm_we;
                    mem_addr_nxt  = dm_addr;
                    mem_wdata_nxt = dm_wdata;
                    if (if_req && starve_cnt < STARVE_MAX)
                        starve_nxt = starve_cnt + 4'd1;
                end else if (grant_if) begin
                    state_nxt     = SERVE_IF;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = 1'b0;
                    mem_addr_nxt  = if_addr;
                    starve_nxt    = 4'd0;
                end
            end
            SERVE_IF: begin
                if (mem_ack) begin
                    state_nxt    = IDLE;
                    mem_req_nxt  = 1'b0;
                    if_rdata_nxt = mem_rdata;
                    if_ready_nxt = 1'b1;
                end
            end
            SERVE_DM: begin
                if (mem_ack) begin
                    state_nxt    = IDLE;
                    mem_req_nxt  = 1'b0;
                    dm_ready_nxt = 1'b1;
                    if (!mem_we)
                        dm_rdata_nxt = mem_rdata;
                end
            end
            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

endmodule
